// File: rtl/cache_2way_wt_if.sv
// Pipeline-side and system-side buses of the 2-way write-through cache.
// slave: the cache itself; master: the environment (pipeline stage plus system memory).
interface cache_2way_wt_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              PStrobe;
  logic [ADDR_W-1:0] PAddress;
  logic [BE_W-1:0]   PRW;
  logic [DATA_W-1:0] PWData;
  logic [DATA_W-1:0] PRData;
  logic              PReady;

  logic              SysStrobe;
  logic [ADDR_W-1:0] SysAddress;
  logic [BE_W-1:0]   SysRW;
  logic [DATA_W-1:0] SysWData;
  logic [DATA_W-1:0] SysRData;
  logic              SysReady;

  modport slave (
    input  PStrobe, PAddress, PRW, PWData, SysRData, SysReady,
    output PRData, PReady, SysStrobe, SysAddress, SysRW, SysWData
  );

  modport master (
    output PStrobe, PAddress, PRW, PWData, SysRData, SysReady,
    input  PRData, PReady, SysStrobe, SysAddress, SysRW, SysWData
  );
endinterface

// File: rtl/cache_2way_wt.sv
// 2-way set-associative write-through, no-write-allocate cache with per-set LRU,
// SysReady handshake to system memory, flush and saturating hit/miss counters.
module cache_2way_wt #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  cache_2way_wt_if.slave     bus,
  input  logic               Flush,
  output logic [CNT_W-1:0]   HitCount,
  output logic [CNT_W-1:0]   MissCount
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;
  localparam int unsigned SETS  = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, RMISS, WSYS} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [BE_W-1:0]    rw_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [TAG_W-1:0]   rd_tag_q  [2];
  logic [DATA_W-1:0]  rd_data_q [2];

  logic [TAG_W-1:0]   tag_mem  [2][SETS];
  logic [DATA_W-1:0]  data_mem [2][SETS];
  logic [SETS-1:0]    valid_q  [2];
  logic [SETS-1:0]    lru_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic [INDEX_W-1:0] set_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit0, hit1, hit_way, victim, is_write;
  logic               accept, flush_clr, hit_inc, miss_inc, wr_hit, fill, lru_upd, lru_val;
  logic               p_ready;
  logic [DATA_W-1:0]  p_rdata;

  assign set_idx  = addr_q[INDEX_W-1:0];
  assign req_tag  = addr_q[ADDR_W-1:INDEX_W];
  assign is_write = |rw_q;
  assign hit0     = valid_q[0][set_idx] && (rd_tag_q[0] == req_tag);
  assign hit1     = valid_q[1][set_idx] && (rd_tag_q[1] == req_tag);
  assign hit_way  = ~hit0;
  // Fill an empty way first; only consult LRU when both ways hold data.
  assign victim   = !valid_q[0][set_idx] ? 1'b0 :
                    !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];

  // Next-state and per-cycle control
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    flush_clr = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    wr_hit    = 1'b0;
    fill      = 1'b0;
    lru_upd   = 1'b0;
    lru_val   = 1'b0;
    p_ready   = 1'b0;
    p_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (Flush) begin
          flush_clr = 1'b1;
        end else if (bus.PStrobe) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          hit_inc = 1'b1;
          lru_upd = 1'b1;
          lru_val = ~hit_way;
          if (is_write) begin
            wr_hit  = 1'b1;
            state_d = WSYS;
          end else begin
            p_ready = 1'b1;
            p_rdata = rd_data_q[hit_way];
            state_d = IDLE;
          end
        end else begin
          miss_inc = 1'b1;
          state_d  = is_write ? WSYS : RMISS;
        end
      end
      RMISS: begin
        if (bus.SysReady) begin
          fill    = 1'b1;
          lru_upd = 1'b1;
          lru_val = ~victim;
          p_ready = 1'b1;
          p_rdata = bus.SysRData;
          state_d = IDLE;
        end
      end
      WSYS: begin
        if (bus.SysReady) begin
          p_ready = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, valid/LRU bits, counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_clr) begin
        valid_q[0] <= '0;
        valid_q[1] <= '0;
      end
      if (fill)    valid_q[victim][set_idx] <= 1'b1;
      if (lru_upd) lru_q[set_idx] <= lru_val;
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  // Request latch, synchronous array read and array writes (not reset)
  always_ff @(posedge Clk) begin
    if (accept) begin
      addr_q       <= bus.PAddress;
      rw_q         <= bus.PRW;
      wdata_q      <= bus.PWData;
      rd_tag_q[0]  <= tag_mem[0][bus.PAddress[INDEX_W-1:0]];
      rd_tag_q[1]  <= tag_mem[1][bus.PAddress[INDEX_W-1:0]];
      rd_data_q[0] <= data_mem[0][bus.PAddress[INDEX_W-1:0]];
      rd_data_q[1] <= data_mem[1][bus.PAddress[INDEX_W-1:0]];
    end
    if (wr_hit) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (rw_q[b]) data_mem[hit_way][set_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
    if (fill) begin
      tag_mem[victim][set_idx]  <= req_tag;
      data_mem[victim][set_idx] <= bus.SysRData;
    end
  end

  assign bus.PReady     = p_ready;
  assign bus.PRData     = p_rdata;
  assign bus.SysStrobe  = (state_q == RMISS) || (state_q == WSYS);
  assign bus.SysAddress = addr_q;
  assign bus.SysRW      = (state_q == WSYS) ? rw_q : '0;
  assign bus.SysWData   = wdata_q;
  assign HitCount       = hit_cnt_q;
  assign MissCount      = miss_cnt_q;
endmodule

// File: tb/tb_cache_2way_wt.sv
// Table-driven bench for cache_2way_wt (4 sets, 2-bit counters) with a read-data
// scoreboard and hand-written flush, reset and saturation sequences.
module tb_cache_2way_wt;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INDEX_W = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int          MAX_CYC = 40;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic [3:0]  delay;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  logic             Clk;
  logic             Reset;
  logic             Flush;
  logic [CNT_W-1:0] HitCount, MissCount;

  cache_2way_wt_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_2way_wt #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .Flush(Flush),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_h    = 0;
  int          exp_m    = 0;
  logic [31:0] exp_q [$];
  vec_t        vecs [30];

  function automatic vec_t mk(input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] sd, input logic [3:0] d, input logic h,
                              input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.be = be; v.wdata = wd; v.sdata = sd; v.delay = d; v.hit = h; v.rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_counters();
    check("hit_count", 32'(HitCount), 32'(exp_h));
    check("miss_count", 32'(MissCount), 32'(exp_m));
  endtask

  // Drive one request, act as system memory, and compare everything it produces.
  task automatic run_req(input vec_t v);
    int   lat, sys_cnt;
    bit   seen_sys, done, rd;
    logic [31:0] exp_d;
    rd = (v.be == 4'b0);
    bus.PStrobe = 1'b1; bus.PAddress = v.addr; bus.PRW = v.be; bus.PWData = v.wdata;
    if (rd) exp_q.push_back(v.rdata);
    lat = 0; sys_cnt = 0; seen_sys = 1'b0; done = 1'b0;
    @(posedge Clk);
    while (!done && lat < MAX_CYC) begin
      #1;
      lat++;
      bus.SysReady = 1'b0;
      if (bus.SysStrobe) begin
        if (!seen_sys) begin
          check("sys_address", 32'(bus.SysAddress), 32'(v.addr));
          check("sys_rw", 32'(bus.SysRW), 32'(v.be));
          if (!rd) check("sys_wdata", bus.SysWData, v.wdata);
        end
        seen_sys = 1'b1;
        if (sys_cnt == int'(v.delay)) begin
          bus.SysReady = 1'b1;
          bus.SysRData = v.sdata;
        end
        sys_cnt++;
      end
      @(negedge Clk);
      if (bus.PReady) begin
        done = 1'b1;
        check("latency", 32'(lat), (rd && v.hit) ? 32'd1 : 32'(2 + int'(v.delay)));
        if (rd) begin
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          check("prdata", bus.PRData, exp_d);
        end
      end
      @(posedge Clk);
    end
    #1;
    bus.PStrobe  = 1'b0;
    bus.SysReady = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL pready_timeout: addr %h got no PReady in %0d cycles, expected one", v.addr, MAX_CYC);
      if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check("sys_strobe_seen", 32'(seen_sys), 32'(!v.hit || !rd));
    if (v.hit) exp_h = (exp_h < 3) ? exp_h + 1 : 3;
    else       exp_m = (exp_m < 3) ? exp_m + 1 : 3;
    check_counters();
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_req(vecs[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge Clk);
    check({tag, "_pready"}, 32'(bus.PReady), 32'd0);
    check({tag, "_sysstrobe"}, 32'(bus.SysStrobe), 32'd0);
    check({tag, "_sysrw"}, 32'(bus.SysRW), 32'd0);
    check({tag, "_prdata"}, bus.PRData, 32'd0);
  endtask

  initial begin
    // addr, be, wdata, sysdata, delay, hit, read data
    vecs[0]  = mk(16'h0040, 4'h0, 32'h0, 32'hDEADBEEF, 4'd3, 1'b0, 32'hDEADBEEF);
    vecs[1]  = mk(16'h0040, 4'h0, 32'h0, 32'h0,        4'd0, 1'b1, 32'hDEADBEEF);
    vecs[2]  = mk(16'h0040, 4'h0, 32'h0, 32'hCAFEF00D, 4'd0, 1'b0, 32'hCAFEF00D);
    vecs[3]  = mk(16'h0000, 4'h0, 32'h0, 32'h11223344, 4'd0, 1'b0, 32'h11223344);
    vecs[4]  = mk(16'h0004, 4'h0, 32'h0, 32'h55667788, 4'd1, 1'b0, 32'h55667788);
    vecs[5]  = mk(16'h0000, 4'h0, 32'h0, 32'h0,        4'd0, 1'b1, 32'h11223344);
    vecs[6]  = mk(16'h0008, 4'h0, 32'h0, 32'h99AABBCC, 4'd2, 1'b0, 32'h99AABBCC);
    vecs[7]  = mk(16'h0000, 4'h0, 32'h0, 32'h0,        4'd0, 1'b1, 32'h11223344);
    vecs[8]  = mk(16'h0004, 4'h0, 32'h0, 32'h55667788, 4'd0, 1'b0, 32'h55667788);
    vecs[9]  = mk(16'h0000, 4'h3, 32'h0000AAAA, 32'h0, 4'd1, 1'b1, 32'h0);
    vecs[10] = mk(16'h0000, 4'h0, 32'h0, 32'h0,        4'd0, 1'b1, 32'h1122AAAA);
    vecs[11] = mk(16'h0100, 4'hF, 32'h12345678, 32'h0, 4'd2, 1'b0, 32'h0);
    vecs[12] = mk(16'h0100, 4'h0, 32'h0, 32'hFEEDFACE, 4'd0, 1'b0, 32'hFEEDFACE);
    vecs[13] = mk(16'h0013, 4'h0, 32'h0, 32'h0BADC0DE, 4'd0, 1'b0, 32'h0BADC0DE);
    vecs[14] = mk(16'h0013, 4'h0, 32'h0, 32'h0,        4'd0, 1'b1, 32'h0BADC0DE);
    vecs[15] = mk(16'h0013, 4'hC, 32'hABCD0000, 32'h0, 4'd0, 1'b1, 32'h0);
    vecs[16] = mk(16'h0013, 4'h0, 32'h0, 32'h0,        4'd0, 1'b1, 32'hABCDC0DE);
    // after reset: previously valid lines miss, then five hits saturate HitCount
    vecs[17] = mk(16'h0000, 4'h0, 32'h0, 32'h11112222, 4'd0, 1'b0, 32'h11112222);
    vecs[18] = mk(16'h0013, 4'h0, 32'h0, 32'h33334444, 4'd1, 1'b0, 32'h33334444);
    for (int i = 19; i <= 23; i++)
      vecs[i] = mk(16'h0013, 4'h0, 32'h0, 32'h0, 4'd0, 1'b1, 32'h33334444);

    Reset = 1'b1; Flush = 1'b0;
    bus.PStrobe = 1'b0; bus.PAddress = '0; bus.PRW = '0; bus.PWData = '0;
    bus.SysReady = 1'b0; bus.SysRData = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check_idle_outputs("reset");
    check_counters();
    @(posedge Clk); #1;

    run_range(0, 1);

    // Flush together with PStrobe: request must wait one cycle, then miss.
    Flush = 1'b1;
    bus.PStrobe = 1'b1; bus.PAddress = 16'h0040; bus.PRW = 4'h0;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check_idle_outputs("flush_prio");
    run_range(2, 2);

    // Plain flush, then LRU, write-through and no-allocate sequences.
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    run_range(3, 16);

    // Reset while a read miss waits on SysReady.
    bus.PStrobe = 1'b1; bus.PAddress = 16'h0200; bus.PRW = 4'h0;
    begin
      int k;
      k = 0;
      while (!bus.SysStrobe && k < MAX_CYC) begin
        @(posedge Clk); #1;
        k++;
      end
      check("rmiss_strobe_before_reset", 32'(bus.SysStrobe), 32'd1);
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    bus.PStrobe = 1'b0;
    exp_h = 0; exp_m = 0;
    check_idle_outputs("mid_reset");
    check_counters();
    @(posedge Clk); #1;
    run_range(17, 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
